load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/fyra_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 38 +++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fyra_pkg.sv
// Shared core encodings: load/store funct3 codes, LSU fault codes and request legality helpers.
// Pure declarations; no state, no timing.
package fyra_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    FAULT_OK       = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_TIMEOUT  = 2'b10,
    FAULT_ILLEGAL  = 2'b11
  } fault_e;

  // Unsigned variants only exist as loads; there is no SBU/SHU.
  function automatic logic f3_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !we;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (f3[1:0])
      2'b01:   bad = addr_lo[0];
      2'b10:   bad = (addr_lo != 2'b00);
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store replication, byte enables and load lane select with sign/zero extension.
// Purely combinational, no backpressure.
module lsu_align
  import fyra_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] store_data,
  output logic [3:0]  byte_en,
  output logic [31:0] load_data
);

  logic [15:0] lane;

  always_comb begin
    lane       = 16'(mem_rdata >> {addr_lo, 3'b000});
    store_data = wdata;
    byte_en    = 4'hF;
    load_data  = mem_rdata;
    case (funct3[1:0])
      2'b00: begin
        store_data = {4{wdata[7:0]}};
        if (we) byte_en = 4'b0001 << addr_lo;
        load_data  = funct3[2] ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
      end
      2'b01: begin
        store_data = {2{wdata[15:0]}};
        if (we) byte_en = 4'b0011 << addr_lo;
        load_data  = funct3[2] ? {16'b0, lane} : {{16{lane[15]}}, lane};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: done 2 cycles after req on first-cycle ack, 1 cycle for rejected requests.
// New req only accepted in IDLE; mem_req held until mem_ack or MAX_WAIT cycles elapse (bus timeout).
module load_store_unit
  import fyra_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  localparam int CW = $clog2(MAX_WAIT + 1);

  state_e        state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    funct3_q;
  logic [1:0]    addr_lo_q;

  logic          al_we;
  logic [2:0]    al_funct3;
  logic [1:0]    al_addr_lo;
  logic [31:0]   al_store_data;
  logic [3:0]    al_byte_en;
  logic [31:0]   al_load_data;

  // One aligner serves both phases: live inputs for the store command in IDLE,
  // the captured request for load extension while the access is in flight.
  assign al_we      = (state == IDLE) ? we           : mem_we;
  assign al_funct3  = (state == IDLE) ? funct3       : funct3_q;
  assign al_addr_lo = (state == IDLE) ? addr[1:0]    : addr_lo_q;

  lsu_align u_align (
    .we         (al_we),
    .funct3     (al_funct3),
    .addr_lo    (al_addr_lo),
    .wdata      (wdata),
    .mem_rdata  (mem_rdata),
    .store_data (al_store_data),
    .byte_en    (al_byte_en),
    .load_data  (al_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      funct3_q  <= '0;
      addr_lo_q <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      fault     <= FAULT_OK;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (req) begin
            funct3_q  <= funct3;
            addr_lo_q <= addr[1:0];
            busy      <= 1'b1;
            if (!f3_legal(we, funct3)) begin
              state <= RESP;
              done  <= 1'b1;
              fault <= FAULT_ILLEGAL;
            end else if (f3_misaligned(funct3, addr[1:0])) begin
              state <= RESP;
              done  <= 1'b1;
              fault <= FAULT_MISALIGN;
            end else begin
              state     <= ACCESS;
              wait_cnt  <= '0;
              mem_req   <= 1'b1;
              mem_we    <= we;
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= al_store_data;
              mem_be    <= al_byte_en;
            end
          end
        end
        ACCESS: begin
          // An ack in the final wait cycle still wins over the timeout.
          if (mem_ack) begin
            state   <= RESP;
            mem_req <= 1'b0;
            done    <= 1'b1;
            fault   <= FAULT_OK;
            if (!mem_we) rdata <= al_load_data;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
            if (wait_cnt == CW'(MAX_WAIT - 1)) begin
              state   <= RESP;
              mem_req <= 1'b0;
              done    <= 1'b1;
              fault   <= FAULT_TIMEOUT;
            end
          end
        end
        RESP: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, multi-cycle corner sequences, and random
// accesses scored against an arithmetic reference model of the load/store rules.
module tb_load_store_unit;

  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst, req, we, mem_ack;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        busy, done, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [1:0]  fault;
  logic [3:0]  mem_be;

  always #5 clk = ~clk;

  load_store_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .funct3(funct3), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .rdata(rdata), .fault(fault),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          done_k;
    logic [1:0]  fault;
    logic [31:0] rdata;
    int          mreq_cyc;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_be;
    bit          stable;
    logic        done_after;
  } res_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, word;
    int          delay;
    logic [31:0] e_rdata;
    logic [1:0]  e_fault;
    int          e_done;
    int          e_mreq;
    logic [31:0] e_maddr, e_mwdata;
    logic [3:0]  e_be;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issue one request for a single cycle, act as memory acking after `delay` mem_req cycles.
  task automatic do_access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] word, input int delay,
                           output res_t r);
    r.done_k = 0; r.fault = 0; r.rdata = 0; r.mreq_cyc = 0; r.m_we = 0;
    r.m_addr = 0; r.m_wdata = 0; r.m_be = 0; r.stable = 1; r.done_after = 0;
    req = 1'b1; we = w; funct3 = f3; addr = a; wdata = wd; mem_ack = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) begin
        req = 1'b0; we = ~w; funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      end
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (done) begin
        r.done_k = k; r.fault = fault; r.rdata = rdata;
        break;
      end
      if (mem_req) begin
        if (r.mreq_cyc == 0) begin
          r.m_we = mem_we; r.m_addr = mem_addr; r.m_wdata = mem_wdata; r.m_be = mem_be;
        end else if (r.m_we !== mem_we || r.m_addr !== mem_addr ||
                     r.m_wdata !== mem_wdata || r.m_be !== mem_be) begin
          r.stable = 0;
        end
        if (r.mreq_cyc == delay) begin
          mem_ack = 1'b1;
          mem_rdata = word;
        end
        r.mreq_cyc++;
      end
    end
    mem_ack = 1'b0;
    tick();
    r.done_after = done;
  endtask

  task automatic compare(input string tag, input res_t r, input res_t e);
    chk($sformatf("%s.done_cycle", tag), r.done_k, e.done_k);
    chk($sformatf("%s.fault", tag), 32'(r.fault), 32'(e.fault));
    chk($sformatf("%s.rdata", tag), r.rdata, e.rdata);
    chk($sformatf("%s.mem_req_cycles", tag), r.mreq_cyc, e.mreq_cyc);
    chk($sformatf("%s.done_one_cycle", tag), 32'(r.done_after), 32'(e.done_after));
    if (e.mreq_cyc > 0) begin
      chk($sformatf("%s.mem_we", tag), 32'(r.m_we), 32'(e.m_we));
      chk($sformatf("%s.mem_addr", tag), r.m_addr, e.m_addr);
      chk($sformatf("%s.mem_be", tag), 32'(r.m_be), 32'(e.m_be));
      chk($sformatf("%s.cmd_stable", tag), 32'(r.stable), 32'(e.stable));
      if (e.m_we) chk($sformatf("%s.mem_wdata", tag), r.m_wdata, e.m_wdata);
    end
  endtask

  // Reference model: derived from access size arithmetic, not from the RTL structure.
  function automatic res_t model(input logic w, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [31:0] word, input int delay,
                                 input logic [31:0] cur_rdata);
    res_t e;
    int sz, sh;
    logic legal;
    logic [31:0] v;
    e.rdata = cur_rdata; e.m_we = w; e.m_addr = 0; e.m_wdata = 0; e.m_be = 0;
    e.stable = 1; e.done_after = 0; e.mreq_cyc = 0;
    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!w && (f3 == 3'd4 || f3 == 3'd5));
    sz = 1 << f3[1:0];
    sh = int'(a % 4);
    if (!legal) begin
      e.fault = 2'b11; e.done_k = 1;
    end else if ((a % sz) != 0) begin
      e.fault = 2'b01; e.done_k = 1;
    end else begin
      e.m_addr  = a & 32'hFFFF_FFFC;
      e.m_be    = w ? 4'(((1 << sz) - 1) << sh) : 4'hF;
      e.m_wdata = (sz == 1) ? wd[7:0] * 32'h0101_0101 :
                  (sz == 2) ? wd[15:0] * 32'h0001_0001 : wd;
      if (delay < MW) begin
        e.fault = 2'b00; e.done_k = 2 + delay; e.mreq_cyc = delay + 1;
        if (!w) begin
          v = word >> (8 * sh);
          if (sz == 1) v = f3[2] ? (v & 32'hFF) : {{24{v[7]}}, v[7:0]};
          else if (sz == 2) v = f3[2] ? (v & 32'hFFFF) : {{16{v[15]}}, v[15:0]};
          e.rdata = v;
        end
      end else begin
        e.fault = 2'b10; e.done_k = MW + 1; e.mreq_cyc = MW;
      end
    end
    return e;
  endfunction

  vec_t tbl[13];
  res_t r, e;
  logic [31:0] cur_rdata;
  int seen_done;

  initial begin
    rst = 1'b1; req = 0; we = 0; funct3 = 0; addr = 0; wdata = 0; mem_ack = 0; mem_rdata = 0;
    tick(); tick();
    chk("reset.busy", 32'(busy), 0);
    chk("reset.done", 32'(done), 0);
    chk("reset.mem_req", 32'(mem_req), 0);
    chk("reset.mem_we", 32'(mem_we), 0);
    chk("reset.rdata", rdata, 0);
    chk("reset.mem_addr", mem_addr, 0);
    chk("reset.mem_wdata", mem_wdata, 0);
    chk("reset.mem_be", 32'(mem_be), 0);
    chk("reset.fault", 32'(fault), 0);
    rst = 1'b0;
    tick();

    //        we    f3    addr          wdata         word          dly rdata         flt  done mreq maddr         mwdata        be
    tbl[0]  = '{1'b0, 3'd0, 32'h103, 32'h0,         32'h80FF1234, 0, 32'hFFFFFF80, 2'd0, 2, 1, 32'h100, 32'h0,         4'hF};
    tbl[1]  = '{1'b0, 3'd5, 32'h102, 32'h0,         32'hBEEF1234, 0, 32'h0000BEEF, 2'd0, 2, 1, 32'h100, 32'h0,         4'hF};
    tbl[2]  = '{1'b1, 3'd0, 32'h101, 32'h000000AB,  32'h0,        0, 32'h0000BEEF, 2'd0, 2, 1, 32'h100, 32'hABABABAB,  4'b0010};
    tbl[3]  = '{1'b0, 3'd2, 32'h102, 32'h0,         32'h0,        0, 32'h0000BEEF, 2'd1, 1, 0, 32'h0,   32'h0,         4'h0};
    tbl[4]  = '{1'b0, 3'd2, 32'h0,   32'h0,         32'h0,        9, 32'h0000BEEF, 2'd2, 5, 4, 32'h0,   32'h0,         4'hF};
    tbl[5]  = '{1'b0, 3'd1, 32'h2,   32'h0,         32'h80017FFF, 0, 32'hFFFF8001, 2'd0, 2, 1, 32'h0,   32'h0,         4'hF};
    tbl[6]  = '{1'b0, 3'd3, 32'h0,   32'h0,         32'h0,        0, 32'hFFFF8001, 2'd3, 1, 0, 32'h0,   32'h0,         4'h0};
    tbl[7]  = '{1'b1, 3'd4, 32'h0,   32'h0,         32'h0,        0, 32'hFFFF8001, 2'd3, 1, 0, 32'h0,   32'h0,         4'h0};
    tbl[8]  = '{1'b0, 3'd2, 32'h200, 32'h0,         32'h12345678, 3, 32'h12345678, 2'd0, 5, 4, 32'h200, 32'h0,         4'hF};
    tbl[9]  = '{1'b1, 3'd1, 32'h106, 32'h1234CAFE,  32'h0,        1, 32'h12345678, 2'd0, 3, 2, 32'h104, 32'hCAFECAFE,  4'b1100};
    tbl[10] = '{1'b0, 3'd4, 32'h100, 32'h0,         32'h000000F0, 0, 32'h000000F0, 2'd0, 2, 1, 32'h100, 32'h0,         4'hF};
    tbl[11] = '{1'b1, 3'd2, 32'h1FC, 32'hDEADBEEF,  32'h0,        2, 32'h000000F0, 2'd0, 4, 3, 32'h1FC, 32'hDEADBEEF,  4'hF};
    tbl[12] = '{1'b0, 3'd0, 32'h1,   32'h0,         32'h00007F00, 0, 32'h0000007F, 2'd0, 2, 1, 32'h0,   32'h0,         4'hF};

    for (int i = 0; i < 13; i++) begin
      do_access(tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].word, tbl[i].delay, r);
      e.done_k = tbl[i].e_done; e.fault = tbl[i].e_fault; e.rdata = tbl[i].e_rdata;
      e.mreq_cyc = tbl[i].e_mreq; e.m_we = tbl[i].we; e.m_addr = tbl[i].e_maddr;
      e.m_wdata = tbl[i].e_mwdata; e.m_be = tbl[i].e_be; e.stable = 1; e.done_after = 0;
      compare($sformatf("vec%0d", i), r, e);
    end

    // req held high: second access starts from the IDLE cycle right after RESP.
    req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h10;
    tick(); chk("b2b.mem_req1", 32'(mem_req), 1);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    tick(); mem_ack = 1'b0;
    chk("b2b.done1", 32'(done), 1); chk("b2b.rdata1", rdata, 32'h11112222);
    tick(); chk("b2b.idle_busy", 32'(busy), 0); chk("b2b.idle_done", 32'(done), 0);
    tick(); chk("b2b.mem_req2", 32'(mem_req), 1);
    req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h33334444;
    tick(); mem_ack = 1'b0;
    chk("b2b.done2", 32'(done), 1); chk("b2b.rdata2", rdata, 32'h33334444);
    tick(); chk("b2b.end_busy", 32'(busy), 0);

    // Stray ack while IDLE must not produce a completion.
    mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
    tick(); mem_ack = 1'b0;
    chk("stray_ack.done", 32'(done), 0); chk("stray_ack.busy", 32'(busy), 0);
    chk("stray_ack.rdata", rdata, 32'h33334444);

    // Reset in the middle of an access.
    req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h40;
    tick(); req = 1'b0;
    chk("rst_mid.mem_req_before", 32'(mem_req), 1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    chk("rst_mid.mem_req", 32'(mem_req), 0);
    chk("rst_mid.done", 32'(done), 0);
    chk("rst_mid.busy", 32'(busy), 0);
    chk("rst_mid.rdata", rdata, 0);
    seen_done = 0;
    for (int k = 0; k < 3; k++) begin
      mem_ack = 1'b1;
      tick();
      if (done) seen_done++;
    end
    mem_ack = 1'b0;
    chk("rst_mid.no_done", seen_done, 0);
    do_access(1'b0, 3'd2, 32'h0, 32'h0, 32'hA5A50F0F, 0, r);
    e = model(1'b0, 3'd2, 32'h0, 32'h0, 32'hA5A50F0F, 0, 32'h0);
    compare("rst_mid.lw0", r, e);
    cur_rdata = 32'hA5A50F0F;

    for (int i = 0; i < 60; i++) begin
      logic        rw;
      logic [2:0]  rf3;
      logic [31:0] ra, rwd, rword;
      int          rd;
      rw = 1'($urandom); rf3 = 3'($urandom_range(0, 7));
      ra = $urandom; rwd = $urandom; rword = $urandom;
      rd = $urandom_range(0, MW + 1);
      e = model(rw, rf3, ra, rwd, rword, rd, cur_rdata);
      do_access(rw, rf3, ra, rwd, rword, rd, r);
      compare($sformatf("rnd%0d", i), r, e);
      cur_rdata = e.rdata;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
